// File: rtl/cpu_control_unit_pkg.sv
// -----------------------------------------------------------------------------
// cpu_control_unit_pkg
//   Shared definitions for the multi-cycle control unit that sequences the
//   core datapath: state encodings, counter widths and the packed strobe
//   bundle the FSM drives each cycle.
//
//   Contents
//     STATE_W        width of the state encoding (3)
//     WAIT_W         width of the fixed-latency memory wait counter (4)
//     WDOG_W         width of the memory handshake watchdog (8 -> 256 cycles)
//     cu_state_e     S_RST=0 S_FETCH=1 S_DEC=2 S_EXE=3 S_MEM=4 S_WB=5 S_HALT=6
//     cu_strobes_t   every non-reserved strobe/status output of the unit
//     STROBES_IDLE   all-zero strobe bundle (default each cycle)
//     clamp_mem_wait helper that folds MEM_WAIT into its legal 1..15 range
// -----------------------------------------------------------------------------
package cpu_control_unit_pkg;

  localparam int STATE_W = 3;
  localparam int WAIT_W  = 4;
  localparam int WDOG_W  = 8;

  typedef enum logic [STATE_W-1:0] {
    S_RST   = 3'd0,
    S_FETCH = 3'd1,
    S_DEC   = 3'd2,
    S_EXE   = 3'd3,
    S_MEM   = 3'd4,
    S_WB    = 3'd5,
    S_HALT  = 3'd6
  } cu_state_e;

  // One field per output pulse/level. Bit order is not significant to the
  // datapath; the fields are unpacked to individual ports in the top.
  typedef struct packed {
    logic ld_ir;
    logic ld_pc;
    logic ld_lr;
    logic ld_rd;
    logic ld_rn;
    logic ld_apsr;
    logic cu_execute;
    logic wr_en;
    logic branch;
    logic led_en;
    logic halted;
  } cu_strobes_t;

  localparam cu_strobes_t STROBES_IDLE = '0;

  // Out-of-range MEM_WAIT values are folded into 1..15 so the 4-bit wait
  // counter can never be loaded with a wrapped value.
  function automatic logic [WAIT_W-1:0] clamp_mem_wait(input int mem_wait);
    int v;
    v = mem_wait;
    if (v < 1)  v = 1;
    if (v > 15) v = 15;
    return WAIT_W'(v);
  endfunction

endpackage

// File: rtl/cpu_control_unit.sv
// -----------------------------------------------------------------------------
// cpu_control_unit
//   Multi-cycle sequencer beside the core datapath. One instruction is in
//   flight at a time; it walks FETCH -> DEC -> [EXE -> [MEM] ->] WB and raises
//   the register-load strobes and execute/memory/branch pulses of each state.
//   Halt / single-step debug control parks the unit in S_HALT before a fetch.
//
//   Build option
//     MEM_HANDSHAKE_EN  defined  : S_MEM waits for mem_ready (256-cycle watchdog)
//                       undefined: S_MEM lasts exactly MEM_WAIT cycles,
//                                  mem_ready is ignored
//
//   Parameters
//     MEM_WAIT  cycles spent in S_MEM without the handshake (1..15)
//     CNT_W     width of the retired-instruction counter
//
//   Ports
//     clk            in   system clock, rising edge
//     rst            in   synchronous reset, active low
//     halt           in   stop before the next fetch
//     step           in   single-cycle pulse: retire one instruction while halted
//     write_rd       in   decoder: instruction writes Rd
//     write_rn       in   decoder: instruction writes Rn (write-back)
//     update_flags   in   decoder: S bit, update APSR
//     mem_en         in   decoder: load/store
//     mem_wr         in   decoder: store (1) / load (0)
//     ig_ex          in   decoder: condition failed, skip execute
//     br_en          in   decoder: branch taken
//     br_L           in   decoder: branch with link
//     mem_ready      in   data memory done (handshake build only)
//     ld_ir ld_pc ld_lr ld_rd ld_rn ld_apsr   out  load strobes
//     ld_sp ld_ipsr ld_primask                out  reserved, tied 0
//     cu_execute     out  ALU evaluate pulse
//     wr_en          out  data-memory write strobe
//     branch         out  PC loads branch target instead of PC+4
//     led_en         out  LED register capture pulse
//     halted         out  1 while parked in S_HALT
//     state          out  current state encoding (debug)
//     retired        out  retired-instruction count
//
//   Handshake semantics: there is no valid/ready pair on the instruction side;
//   the only handshake is mem_ready, a level sampled in S_MEM. The cycle in
//   which mem_ready=1 is seen is the last S_MEM cycle (wr_en still high); the
//   next cycle is S_WB.
// -----------------------------------------------------------------------------
module cpu_control_unit
  import cpu_control_unit_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic             step,
  input  logic             write_rd,
  input  logic             write_rn,
  input  logic             update_flags,
  input  logic             mem_en,
  input  logic             mem_wr,
  input  logic             ig_ex,
  input  logic             br_en,
  input  logic             br_L,
  input  logic             mem_ready,
  output logic             ld_ir,
  output logic             ld_pc,
  output logic             ld_lr,
  output logic             ld_rd,
  output logic             ld_rn,
  output logic             ld_apsr,
  output logic             ld_sp,
  output logic             ld_ipsr,
  output logic             ld_primask,
  output logic             cu_execute,
  output logic             wr_en,
  output logic             branch,
  output logic             led_en,
  output logic             halted,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0] retired
);

  // ---------------------------------------------------------------------------
  // State and bookkeeping registers
  // ---------------------------------------------------------------------------
  cu_state_e        state_q, state_d;
  logic             skip_q, skip_d;            // condition failed: WB only bumps PC
  logic             step_pend_q, step_pend_d;  // step accepted in S_HALT, not yet fetched
  logic [CNT_W-1:0] retired_q, retired_d;
  cu_strobes_t      strb;

`ifdef MEM_HANDSHAKE_EN
  localparam logic [WDOG_W-1:0] WDOG_LAST = {WDOG_W{1'b1}};
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  // MEM_WAIT plays no part in this build.
`else
  localparam logic [WAIT_W-1:0] MEM_LOAD = clamp_mem_wait(MEM_WAIT) - WAIT_W'(1);
  logic [WAIT_W-1:0] wait_q, wait_d;

  // Memory completion is purely time-based in this build.
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_RST;
      skip_q      <= 1'b0;
      step_pend_q <= 1'b0;
      retired_q   <= '0;
`ifdef MEM_HANDSHAKE_EN
      wdog_q      <= '0;
`else
      wait_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      step_pend_q <= step_pend_d;
      retired_q   <= retired_d;
`ifdef MEM_HANDSHAKE_EN
      wdog_q      <= wdog_d;
`else
      wait_q      <= wait_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    step_pend_d = step_pend_q;
    retired_d   = retired_q;
    strb        = STROBES_IDLE;
`ifdef MEM_HANDSHAKE_EN
    wdog_d      = wdog_q;
`else
    wait_d      = wait_q;
`endif

    case (state_q)
      S_RST: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        skip_d = 1'b0;
        // The halt check lives here so a halted core never latches a new
        // instruction: ld_ir is suppressed in the cycle that diverts to
        // S_HALT. A pending step overrides halt for exactly one fetch.
        if (halt && !step_pend_q) begin
          state_d = S_HALT;
        end else begin
          strb.ld_ir  = 1'b1;
          step_pend_d = 1'b0;
          state_d     = S_DEC;
        end
      end

      S_HALT: begin
        strb.halted = 1'b1;
        if (step || !halt) begin
          state_d     = S_FETCH;
          step_pend_d = step;
        end
      end

      S_DEC: begin
        if (ig_ex) begin
          skip_d  = 1'b1;
          state_d = S_WB;
        end else begin
          state_d = S_EXE;
        end
      end

      S_EXE: begin
        strb.cu_execute = 1'b1;
        if (mem_en) begin
          state_d = S_MEM;
`ifdef MEM_HANDSHAKE_EN
          wdog_d  = '0;
`else
          wait_d  = MEM_LOAD;
`endif
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        strb.wr_en = mem_wr;
`ifdef MEM_HANDSHAKE_EN
        // The watchdog keeps a memory that never answers from wedging the core.
        if (mem_ready || (wdog_q == WDOG_LAST)) begin
          state_d = S_WB;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
`else
        if (wait_q == '0) begin
          state_d = S_WB;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
`endif
      end

      S_WB: begin
        strb.ld_pc = 1'b1;
        // Decoder outputs have been stable since S_DEC, so gating the
        // write-back strobes with them directly is glitch-safe in practice.
        if (!skip_q) begin
          strb.ld_rd   = write_rd;
          strb.ld_rn   = write_rn;
          strb.ld_apsr = update_flags;
          strb.branch  = br_en;
          strb.ld_lr   = br_en & br_L;
          strb.led_en  = write_rd;
        end
        retired_d = retired_q + CNT_W'(1);
        state_d   = S_FETCH;
      end

      default: begin
        state_d = S_RST;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ld_ir      = strb.ld_ir;
  assign ld_pc      = strb.ld_pc;
  assign ld_lr      = strb.ld_lr;
  assign ld_rd      = strb.ld_rd;
  assign ld_rn      = strb.ld_rn;
  assign ld_apsr    = strb.ld_apsr;
  assign cu_execute = strb.cu_execute;
  assign wr_en      = strb.wr_en;
  assign branch     = strb.branch;
  assign led_en     = strb.led_en;
  assign halted     = strb.halted;

  // Reserved for the exception/stack extension of the datapath.
  assign ld_sp      = 1'b0;
  assign ld_ipsr    = 1'b0;
  assign ld_primask = 1'b0;

  assign state      = state_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// -----------------------------------------------------------------------------
// tb_cpu_control_unit
//   Directed bench for cpu_control_unit with MEM_WAIT=3. Each task walks one
//   scenario cycle by cycle and compares state, the strobe bundle and the
//   retired counter against hand-derived values. Tasks start and end with the
//   DUT in S_FETCH (except test_reset, which brings it there).
//   Outputs are sampled 1 time unit after each rising edge.
//   MEM_HANDSHAKE_EN, when defined, also enables the held-wr_en scenario.
// -----------------------------------------------------------------------------
module tb_cpu_control_unit;

  logic        clk, rst, halt, step;
  logic        write_rd, write_rn, update_flags, mem_en, mem_wr;
  logic        ig_ex, br_en, br_L, mem_ready;
  logic        ld_ir, ld_pc, ld_lr, ld_rd, ld_rn, ld_apsr;
  logic        ld_sp, ld_ipsr, ld_primask;
  logic        cu_execute, wr_en, branch, led_en, halted;
  logic [2:0]  state;
  logic [31:0] retired;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_ret;

  // Strobe vector: {ir,pc,lr,rd,rn,apsr,exe,wr,br,led,halted}
  logic [10:0] strb;
  assign strb = {ld_ir, ld_pc, ld_lr, ld_rd, ld_rn, ld_apsr,
                 cu_execute, wr_en, branch, led_en, halted};

  localparam logic [10:0] E_IR   = 11'h400;
  localparam logic [10:0] E_PC   = 11'h200;
  localparam logic [10:0] E_LR   = 11'h100;
  localparam logic [10:0] E_RD   = 11'h080;
  localparam logic [10:0] E_APSR = 11'h020;
  localparam logic [10:0] E_EXE  = 11'h010;
  localparam logic [10:0] E_WR   = 11'h008;
  localparam logic [10:0] E_BR   = 11'h004;
  localparam logic [10:0] E_LED  = 11'h002;
  localparam logic [10:0] E_HLT  = 11'h001;

  localparam logic [2:0] ST_RST = 3'd0, ST_FETCH = 3'd1, ST_DEC = 3'd2,
                         ST_EXE = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5,
                         ST_HALT = 3'd6;

  cpu_control_unit #(.MEM_WAIT(3), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .halt(halt), .step(step),
    .write_rd(write_rd), .write_rn(write_rn), .update_flags(update_flags),
    .mem_en(mem_en), .mem_wr(mem_wr), .ig_ex(ig_ex), .br_en(br_en),
    .br_L(br_L), .mem_ready(mem_ready),
    .ld_ir(ld_ir), .ld_pc(ld_pc), .ld_lr(ld_lr), .ld_rd(ld_rd),
    .ld_rn(ld_rn), .ld_apsr(ld_apsr), .ld_sp(ld_sp), .ld_ipsr(ld_ipsr),
    .ld_primask(ld_primask), .cu_execute(cu_execute), .wr_en(wr_en),
    .branch(branch), .led_en(led_en), .halted(halted), .state(state),
    .retired(retired)
  );

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic wrd, input logic wrn, input logic uf,
                         input logic me, input logic mw, input logic ig,
                         input logic be, input logic bl);
    write_rd = wrd; write_rn = wrn; update_flags = uf; mem_en = me;
    mem_wr = mw; ig_ex = ig; br_en = be; br_L = bl;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0; halt = 1'b0; step = 1'b0; mem_ready = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    checks++;
    if (state !== ST_RST || strb !== 11'h000) begin
      errors++;
      $display("FAIL reset_state: state=%0d strb=%b, want state=0 strb=0", state, strb);
    end
    checks++;
    if (retired !== 32'd0 || {ld_sp, ld_ipsr, ld_primask} !== 3'b000) begin
      errors++;
      $display("FAIL reset_regs: retired=%0d reserved=%b, want 0 and 000",
               retired, {ld_sp, ld_ipsr, ld_primask});
    end
    exp_ret = 32'd0;
    // Release: this cycle is "cycle 0" (still S_RST), FETCH follows.
    rst = 1'b1;
    tick();
    checks++;
    if (state !== ST_FETCH || strb !== E_IR) begin
      errors++;
      $display("FAIL reset_release_fetch: state=%0d strb=%b, want state=1 strb=%b",
               state, strb, E_IR);
    end
  endtask

  task automatic test_alu();
    set_dec(1, 0, 1, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (state !== ST_DEC || strb !== 11'h000) begin
      errors++;
      $display("FAIL alu_dec: state=%0d strb=%b, want state=2 strb=0", state, strb);
    end
    tick();
    checks++;
    if (state !== ST_EXE || strb !== E_EXE) begin
      errors++;
      $display("FAIL alu_exe: state=%0d strb=%b, want state=3 strb=%b", state, strb, E_EXE);
    end
    tick();
    checks++;
    if (state !== ST_WB || strb !== (E_PC | E_RD | E_APSR | E_LED)) begin
      errors++;
      $display("FAIL alu_wb: state=%0d strb=%b, want state=5 strb=%b",
               state, strb, E_PC | E_RD | E_APSR | E_LED);
    end
    tick();
    exp_ret++;
    checks++;
    if (state !== ST_FETCH || retired !== exp_ret || strb !== E_IR) begin
      errors++;
      $display("FAIL alu_retire: state=%0d retired=%0d strb=%b, want state=1 retired=%0d strb=%b",
               state, retired, strb, exp_ret, E_IR);
    end
  endtask

  task automatic test_ig_ex();
    set_dec(1, 0, 1, 0, 0, 1, 0, 0);
    tick();
    checks++;
    if (state !== ST_DEC || strb !== 11'h000) begin
      errors++;
      $display("FAIL igex_dec: state=%0d strb=%b, want state=2 strb=0", state, strb);
    end
    tick();
    checks++;
    if (state !== ST_WB || strb !== E_PC) begin
      errors++;
      $display("FAIL igex_wb: state=%0d strb=%b, want state=5 strb=%b", state, strb, E_PC);
    end
    tick();
    exp_ret++;
    checks++;
    if (state !== ST_FETCH || retired !== exp_ret) begin
      errors++;
      $display("FAIL igex_retire: state=%0d retired=%0d, want state=1 retired=%0d",
               state, retired, exp_ret);
    end
  endtask

  task automatic test_store();
    set_dec(0, 0, 0, 1, 1, 0, 0, 0);
    tick();
    tick();
    checks++;
    if (state !== ST_EXE || strb !== E_EXE) begin
      errors++;
      $display("FAIL store_exe: state=%0d strb=%b, want state=3 strb=%b", state, strb, E_EXE);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (state !== ST_MEM || strb !== E_WR) begin
        errors++;
        $display("FAIL store_mem%0d: state=%0d strb=%b, want state=4 strb=%b",
                 i, state, strb, E_WR);
      end
      mem_ready = (i == 2);
    end
    tick();
    mem_ready = 1'b0;
    checks++;
    if (state !== ST_WB || strb !== E_PC) begin
      errors++;
      $display("FAIL store_wb: state=%0d strb=%b, want state=5 strb=%b", state, strb, E_PC);
    end
    tick();
    exp_ret++;
    checks++;
    if (state !== ST_FETCH || retired !== exp_ret) begin
      errors++;
      $display("FAIL store_retire: state=%0d retired=%0d, want state=1 retired=%0d",
               state, retired, exp_ret);
    end
  endtask

  task automatic test_bl();
    set_dec(0, 0, 0, 0, 0, 0, 1, 1);
    tick();
    tick();
    tick();
    checks++;
    if (state !== ST_WB || strb !== (E_PC | E_LR | E_BR)) begin
      errors++;
      $display("FAIL bl_wb: state=%0d strb=%b, want state=5 strb=%b",
               state, strb, E_PC | E_LR | E_BR);
    end
    tick();
    exp_ret++;
    checks++;
    if (state !== ST_FETCH || retired !== exp_ret) begin
      errors++;
      $display("FAIL bl_next: state=%0d retired=%0d, want state=1 retired=%0d",
               state, retired, exp_ret);
    end
  endtask

  task automatic test_halt_step();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    // A step pulse while running must not leave a pending step behind.
    step = 1'b1;
    tick();
    step = 1'b0;
    halt = 1'b1;
    checks++;
    if (state !== ST_EXE || strb !== E_EXE) begin
      errors++;
      $display("FAIL halt_exe: state=%0d strb=%b, want state=3 strb=%b", state, strb, E_EXE);
    end
    tick();
    checks++;
    if (state !== ST_WB || strb !== E_PC) begin
      errors++;
      $display("FAIL halt_wb: state=%0d strb=%b, want state=5 strb=%b", state, strb, E_PC);
    end
    tick();
    exp_ret++;
    checks++;
    if (state !== ST_FETCH || strb !== 11'h000 || retired !== exp_ret) begin
      errors++;
      $display("FAIL halt_fetch_gated: state=%0d strb=%b retired=%0d, want state=1 strb=0 retired=%0d",
               state, strb, retired, exp_ret);
    end
    tick();
    tick();
    checks++;
    if (state !== ST_HALT || strb !== E_HLT) begin
      errors++;
      $display("FAIL halt_parked: state=%0d strb=%b, want state=6 strb=%b", state, strb, E_HLT);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    checks++;
    if (state !== ST_FETCH || strb !== E_IR) begin
      errors++;
      $display("FAIL step_fetch: state=%0d strb=%b, want state=1 strb=%b", state, strb, E_IR);
    end
    repeat (3) tick();
    checks++;
    if (state !== ST_WB || strb !== E_PC) begin
      errors++;
      $display("FAIL step_wb: state=%0d strb=%b, want state=5 strb=%b", state, strb, E_PC);
    end
    tick();
    tick();
    exp_ret++;
    checks++;
    if (state !== ST_HALT || retired !== exp_ret) begin
      errors++;
      $display("FAIL step_rehalt: state=%0d retired=%0d, want state=6 retired=%0d",
               state, retired, exp_ret);
    end
    halt = 1'b0;
    tick();
    checks++;
    if (state !== ST_FETCH || strb !== E_IR) begin
      errors++;
      $display("FAIL halt_resume: state=%0d strb=%b, want state=1 strb=%b", state, strb, E_IR);
    end
  endtask

  task automatic test_reset_mid();
    set_dec(0, 0, 0, 1, 1, 0, 0, 0);
    mem_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if (state !== ST_MEM || strb !== E_WR) begin
      errors++;
      $display("FAIL rstmid_mem: state=%0d strb=%b, want state=4 strb=%b", state, strb, E_WR);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (state !== ST_RST || strb !== 11'h000 || retired !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_reset: state=%0d strb=%b retired=%0d, want state=0 strb=0 retired=0",
               state, strb, retired);
    end
    exp_ret = 32'd0;
    rst = 1'b1;
    tick();
    checks++;
    if (state !== ST_FETCH || strb !== E_IR) begin
      errors++;
      $display("FAIL rstmid_refetch: state=%0d strb=%b, want state=1 strb=%b", state, strb, E_IR);
    end
`ifdef MEM_HANDSHAKE_EN
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (state !== ST_MEM || wr_en !== 1'b1) begin
        errors++;
        $display("FAIL hs_hold%0d: state=%0d wr_en=%b, want state=4 wr_en=1", i, state, wr_en);
      end
      mem_ready = (i == 9);
    end
    tick();
    mem_ready = 1'b0;
    checks++;
    if (state !== ST_WB || strb !== E_PC) begin
      errors++;
      $display("FAIL hs_wb: state=%0d strb=%b, want state=5 strb=%b", state, strb, E_PC);
    end
    tick();
    exp_ret++;
    checks++;
    if (state !== ST_FETCH || retired !== exp_ret) begin
      errors++;
      $display("FAIL hs_retire: state=%0d retired=%0d, want state=1 retired=%0d",
               state, retired, exp_ret);
    end
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_alu();
    test_ig_ex();
    test_store();
    test_bl();
    test_halt_step();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
